decimal_sub_sequencer: RTL and testbench

//  Multi-cycle controller for decimal floating-point subtraction R = A - B on 7-digit BCD mantissas.

---
 rtl/decimal_sub_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_decimal_sub_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/decimal_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decimal_sub_sequencer
// Purpose  : Multi-cycle decimal floating-point subtractor, R = A - B, on
//            DIGITS-digit BCD mantissas. It aligns the exponents, then runs a
//            digit-serial BCD add or subtract (one digit per cycle, least
//            significant digit first). After that it applies the sign fix-up
//            (ten's complement), carry renormalisation and optional
//            leading-zero normalisation, and raises the result flags.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//            a_sign/a_exp/a_man, b_sign/b_exp/b_man   operands
//            out_valid/out_ready result handshake (result held until accepted)
//            r_sign/r_exp/r_man  result
//            overflow/underflow/inexact  flags, valid with out_valid
//            busy                high whenever not IDLE
// Config   : DSUB_NORM_EN - when defined, NORM shifts out leading zeros.
//            When undefined, the result is left unnormalised.
// Revision : 1.0  initial release
// ============================================================================
module decimal_sub_sequencer #(
  parameter int unsigned DIGITS  = 7,
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned EXP_MAX = 'hC0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  a_sign,
  input  logic [EXP_W-1:0]      a_exp,
  input  logic [4*DIGITS-1:0]   a_man,
  input  logic                  b_sign,
  input  logic [EXP_W-1:0]      b_exp,
  input  logic [4*DIGITS-1:0]   b_man,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  r_sign,
  output logic [EXP_W-1:0]      r_exp,
  output logic [4*DIGITS-1:0]   r_man,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact,
  output logic                  busy
);

  localparam int unsigned MW    = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ARITH, S_FIX, S_CARRY, S_NORM, S_DONE
  } state_t;

  state_t             r_state;
  logic [MW-1:0]      r_man_a, r_man_b, r_res;
  logic [EXP_W-1:0]   r_exp_acc, r_diff;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;     // carry (add) or borrow (sub / fix)
  logic               r_sticky;
  logic               r_shift_a;   // A has the smaller exponent
  logic               r_eff_add;
  logic               r_a_sign;
  logic               r_neg;       // FIX ran: magnitude result was negative

  // ---------------- digit-serial BCD adder / subtractor --------------------
  logic [3:0] w_op_a, w_op_b, w_digit, w_drop;
  logic [4:0] w_sum, w_sum_adj, w_dif, w_dif_adj;
  logic       w_cout;

  always_comb begin
    w_op_a = r_man_a[3:0];
    w_op_b = r_man_b[3:0];
    // Ten's complement is computed as 0 - R with the same subtractor.
    if (r_state == S_FIX) begin
      w_op_a = 4'd0;
      w_op_b = r_res[3:0];
    end
    w_sum     = {1'b0, w_op_a} + {1'b0, w_op_b} + {4'd0, r_carry};
    w_sum_adj = w_sum - 5'd10;
    // Bias by 10 so the difference never goes negative; < 10 means borrow.
    w_dif     = {1'b0, w_op_a} + 5'd10 - {1'b0, w_op_b} - {4'd0, r_carry};
    w_dif_adj = w_dif - 5'd10;
    if (r_state == S_ARITH && r_eff_add) begin
      w_cout  = (w_sum > 5'd9);
      w_digit = w_cout ? w_sum_adj[3:0] : w_sum[3:0];
    end else begin
      w_cout  = (w_dif < 5'd10);
      w_digit = w_cout ? w_dif[3:0] : w_dif_adj[3:0];
    end
    w_drop = r_shift_a ? r_man_a[3:0] : r_man_b[3:0];
  end

  // ---------------- normalisation control ----------------------------------
  logic w_msd_zero, w_res_nz, w_norm_shift, w_unf;
  assign w_msd_zero = (r_res[MW-1 -: 4] == 4'd0);
  assign w_res_nz   = |r_res;
`ifdef DSUB_NORM_EN
  assign w_norm_shift = w_msd_zero && w_res_nz && (r_exp_acc != '0);
  assign w_unf        = w_msd_zero && w_res_nz && (r_exp_acc == '0);
`else
  assign w_norm_shift = 1'b0;
  assign w_unf        = 1'b0;
`endif

  logic w_ovf;
  assign w_ovf = (r_exp_acc >= EXP_W'(EXP_MAX));

  // ---------------- sequencer ----------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_man_a   <= '0;
      r_man_b   <= '0;
      r_res     <= '0;
      r_exp_acc <= '0;
      r_diff    <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_sticky  <= 1'b0;
      r_shift_a <= 1'b0;
      r_eff_add <= 1'b0;
      r_a_sign  <= 1'b0;
      r_neg     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_man     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_man_a   <= a_man;
            r_man_b   <= b_man;
            r_a_sign  <= a_sign;
            r_eff_add <= a_sign ^ b_sign;
            r_shift_a <= (a_exp < b_exp);
            r_exp_acc <= (a_exp >= b_exp) ? a_exp : b_exp;
            r_diff    <= (a_exp >= b_exp) ? (a_exp - b_exp) : (b_exp - a_exp);
            r_sticky  <= 1'b0;
            r_neg     <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (r_diff > EXP_W'(DIGITS)) begin
            // Everything would fall off the end: zero it in one step.
            if (r_shift_a) begin
              r_sticky <= r_sticky | (|r_man_a);
              r_man_a  <= '0;
            end else begin
              r_sticky <= r_sticky | (|r_man_b);
              r_man_b  <= '0;
            end
            r_diff <= '0;
          end else if (r_diff != '0) begin
            r_sticky <= r_sticky | (w_drop != 4'd0);
            if (r_shift_a) r_man_a <= {4'd0, r_man_a[MW-1:4]};
            else           r_man_b <= {4'd0, r_man_b[MW-1:4]};
            r_diff <= r_diff - 1'b1;
          end else begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_state <= S_ARITH;
          end
        end
        S_ARITH: begin
          // Result digits enter at the top so the LSD ends up at [3:0].
          r_res   <= {w_digit, r_res[MW-1:4]};
          r_man_a <= {4'd0, r_man_a[MW-1:4]};
          r_man_b <= {4'd0, r_man_b[MW-1:4]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DIGITS - 1)) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            if (w_cout && !r_eff_add) begin
              r_neg   <= 1'b1;
              r_state <= S_FIX;
            end else if (w_cout) begin
              r_state <= S_CARRY;
            end else begin
              r_state <= S_NORM;
            end
          end
        end
        S_FIX: begin
          r_res   <= {w_digit, r_res[MW-1:4]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DIGITS - 1)) r_state <= S_NORM;
        end
        S_CARRY: begin
          r_sticky  <= r_sticky | (r_res[3:0] != 4'd0);
          r_res     <= {4'b0001, r_res[MW-1:4]};
          r_exp_acc <= r_exp_acc + 1'b1;
          r_state   <= S_NORM;
        end
        S_NORM: begin
          if (w_norm_shift) begin
            r_res     <= {r_res[MW-5:0], 4'd0};
            r_exp_acc <= r_exp_acc - 1'b1;
          end else begin
            r_man     <= r_res;
            r_exp     <= r_exp_acc;
            r_sign    <= w_res_nz ? (r_neg ? ~r_a_sign : r_a_sign) : 1'b0;
            overflow  <= w_ovf;
            underflow <= w_unf;
            inexact   <= r_sticky | w_ovf;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decimal_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decimal_sub_sequencer
// Purpose  : Directed self-checking bench for decimal_sub_sequencer. Expected
//            results are queued when operands are issued and compared when
//            out_valid appears. Honours DSUB_NORM_EN for the expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_decimal_sub_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        a_sign = 1'b0, b_sign = 1'b0;
  logic [7:0]  a_exp = '0, b_exp = '0;
  logic [27:0] a_man = '0, b_man = '0;
  logic        out_valid, out_ready = 1'b0;
  logic        r_sign;
  logic [7:0]  r_exp;
  logic [27:0] r_man;
  logic        overflow, underflow, inexact, busy;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic        ovf, unf, inx;
    int          lat;
  } exp_t;
  exp_t sb[$];

  decimal_sub_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
    .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_sign(r_sign), .r_exp(r_exp), .r_man(r_man),
    .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input string tag,
                      input logic as, input logic [7:0] ae, input logic [27:0] am,
                      input logic bs, input logic [7:0] be, input logic [27:0] bm,
                      input exp_t x);
    int cyc = 0;
    while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a_sign = as; a_exp = ae; a_man = am;
    b_sign = bs; b_exp = be; b_man = bm;
    in_valid = 1'b1;
    sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input int hold);
    int cyc = 0;
    exp_t x;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    x = sb.pop_front();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (!out_valid) return;
    chk({tag, "_latency"}, 32'(cyc), 32'(x.lat));
    chk({tag, "_sign"}, 32'(r_sign), 32'(x.s));
    chk({tag, "_exp"}, 32'(r_exp), 32'(x.e));
    chk({tag, "_man"}, 32'(r_man), 32'(x.m));
    chk({tag, "_ovf"}, 32'(overflow), 32'(x.ovf));
    chk({tag, "_unf"}, 32'(underflow), 32'(x.unf));
    chk({tag, "_inx"}, 32'(inexact), 32'(x.inx));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_man"}, 32'(r_man), 32'(x.m));
      chk({tag, "_hold_exp"}, 32'(r_exp), 32'(x.e));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                              input logic ovf, input logic unf, input logic inx, input int lat);
    exp_t x;
    x.s = s; x.e = e; x.m = m; x.ovf = ovf; x.unf = unf; x.inx = inx; x.lat = lat;
    return x;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_r_man", 32'(r_man), 32'd0);
    chk("rst_flags", {29'd0, overflow, underflow, inexact}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain subtract, latency 1 + 7 + 1
    send("t1", 0, 8'h40, 28'h5000000, 0, 8'h40, 28'h2000000, mk(0, 8'h40, 28'h3000000, 0, 0, 0, 9));
    chk("t1_busy", 32'(busy), 32'd1);
    receive("t1", 0);

    // Borrow -> ten's complement, sign flips
    send("t2", 0, 8'h40, 28'h2000000, 0, 8'h40, 28'h5000000, mk(1, 8'h40, 28'h3000000, 0, 0, 0, 16));
    receive("t2", 0);

    // Two alignment shifts drop nonzero digits
    send("t3", 0, 8'h42, 28'h1000000, 0, 8'h40, 28'h0000015, mk(0, 8'h42, 28'h1000000, 0, 0, 1, 11));
    receive("t3", 0);

    // Effective add with carry-out
    send("t4", 0, 8'h40, 28'h9000000, 1, 8'h40, 28'h2000000, mk(0, 8'h41, 28'h1100000, 0, 0, 0, 10));
    receive("t4", 0);

    // Carry pushes exponent to EXP_MAX
    send("t4o", 0, 8'hBF, 28'h9000000, 1, 8'hBF, 28'h2000000, mk(0, 8'hC0, 28'h1100000, 1, 0, 1, 10));
    receive("t4o", 0);

`ifdef DSUB_NORM_EN
    send("t5", 0, 8'h40, 28'h1234567, 0, 8'h40, 28'h1230000, mk(0, 8'h3D, 28'h4567000, 0, 0, 0, 12));
    receive("t5", 0);
    send("t5u", 0, 8'h01, 28'h0000050, 0, 8'h01, 28'h0000010, mk(0, 8'h00, 28'h0000400, 0, 1, 0, 10));
    receive("t5u", 0);
`else
    send("t5", 0, 8'h40, 28'h1234567, 0, 8'h40, 28'h1230000, mk(0, 8'h40, 28'h0004567, 0, 0, 0, 9));
    receive("t5", 0);
    send("t5u", 0, 8'h01, 28'h0000050, 0, 8'h01, 28'h0000010, mk(0, 8'h01, 28'h0000040, 0, 0, 0, 9));
    receive("t5u", 0);
`endif

    // Exponent gap beyond DIGITS: zeroed in one cycle
    send("tbig", 0, 8'h50, 28'h1000000, 0, 8'h40, 28'h1234567, mk(0, 8'h50, 28'h1000000, 0, 0, 1, 10));
    receive("tbig", 0);

    // Negative A, effective add: result keeps A's sign
    send("tneg", 1, 8'h40, 28'h1000000, 0, 8'h40, 28'h2000000, mk(1, 8'h40, 28'h3000000, 0, 0, 0, 9));
    receive("tneg", 0);

    // Exact cancellation: zero result is positive
    send("tzero", 1, 8'h40, 28'h4444444, 1, 8'h40, 28'h4444444, mk(0, 8'h40, 28'h0000000, 0, 0, 0, 9));
    receive("tzero", 0);

    // Back-pressure: hold out_ready low for 5 cycles
    send("t6h", 0, 8'h40, 28'h5000000, 0, 8'h40, 28'h2000000, mk(0, 8'h40, 28'h3000000, 0, 0, 0, 9));
    receive("t6h", 5);

    // Reset in the middle of ARITH aborts the operation
    send("t6r", 0, 8'h40, 28'h9000000, 0, 8'h40, 28'h1000000, mk(0, 8'h40, 28'h8000000, 0, 0, 0, 9));
    repeat (3) begin @(posedge clk); #1; end
    chk("t6r_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6r_out_valid", 32'(out_valid), 32'd0);
    chk("t6r_busy", 32'(busy), 32'd0);
    chk("t6r_r_man", 32'(r_man), 32'd0);
    chk("t6r_r_exp", 32'(r_exp), 32'd0);
    chk("t6r_r_sign", 32'(r_sign), 32'd0);
    chk("t6r_in_ready", 32'(in_ready), 32'd1);
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("t6n", 0, 8'h40, 28'h9000000, 0, 8'h40, 28'h1000000, mk(0, 8'h40, 28'h8000000, 0, 0, 0, 9));
    receive("t6n", 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog: never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
